layer_inter_convfc_reader: RTL and testbench

//  Read side of the conv->fc inter-layer feature buffer. Runs while the inter-layer

---
 rtl/layer_inter_pkg.sv | 30 +++
 rtl/convfc_read_fifo.sv | 61 ++++++
 rtl/layer_inter_convfc_reader.sv | 185 ++++++++++++++++++
 tb/tb_layer_inter_convfc_reader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_inter_pkg.sv
// Shared definitions for the conv->fc inter-layer buffer reader: FSM encoding,
// FIFO sizing and a constant-evaluable clog2.
package layer_inter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Two slots beyond the RAM pipeline keep one pair per cycle flowing.
    localparam int FIFO_SLACK = 2;

    function automatic int fifo_depth_f(input int ram_latency);
        return ram_latency + FIFO_SLACK;
    endfunction

    function automatic int clog2_f(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                bits = i + 1;
            end else begin
                bits = bits;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/convfc_read_fifo.sv
// Synchronous FIFO holding {last, word_a, word_b} entries between the RAM read
// pipeline and the fc MAC handshake; head is presented whenever non-empty.
module convfc_read_fifo
    import layer_inter_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int CW   = clog2_f(DEPTH + 1)
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CW-1:0]    count
);

    localparam int PW = clog2_f(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    function automatic logic [PW-1:0] ptr_next_f(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : ptr + PW'(1);
    endfunction

    // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_next_f(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_next_f(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_valid = (count_r != {CW{1'b0}});
    assign head_data  = head_valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    assign count      = count_r;

endmodule

// File: rtl/layer_inter_convfc_reader.sv
// Read side of the conv->fc feature buffer: issues paired RAM reads under a credit
// limit, absorbs RAM latency and streams pairs to the fc MAC. FCREAD_MULTIPASS_EN
// enables NUM_PASSES passes over the buffer with pass_idx reporting the pass.
module layer_inter_convfc_reader
    import layer_inter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_WORDS   = 400,
    parameter int RAM_LATENCY = 2,
    parameter int NUM_PASSES  = 4
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  rden_a,
    output logic                  rden_b,
    output logic                  wren_a,
    output logic                  wren_b,
    output logic [ADDR_WIDTH-1:0] address_a,
    output logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data_a,
    output logic [DATA_WIDTH-1:0] out_data_b,
    output logic                  out_last,
    output logic [2:0]            pass_idx,
    output logic                  done
);

    localparam int FIFO_DEPTH = fifo_depth_f(RAM_LATENCY);
    localparam int CW         = clog2_f(FIFO_DEPTH + 1);
    localparam int KW         = ADDR_WIDTH - 1;
    localparam int FW         = 2 * DATA_WIDTH + 1;
    localparam logic [KW-1:0] LAST_PAIR = KW'(NUM_WORDS / 2 - 1);
`ifdef FCREAD_MULTIPASS_EN
    localparam logic [2:0] LAST_PASS = 3'(NUM_PASSES - 1);
`else
    localparam logic [2:0] LAST_PASS = 3'd0;
`endif

    if ((NUM_WORDS % 2) != 0 || NUM_WORDS < 2 || NUM_WORDS > (2 ** ADDR_WIDTH)) begin : g_bad_words
        $error("NUM_WORDS must be even, non-zero and fit in the buffer");
    end
    if (NUM_PASSES < 1 || NUM_PASSES > 8 || RAM_LATENCY < 1 || ADDR_WIDTH < 2) begin : g_bad_cfg
        $error("NUM_PASSES must be 1..8, RAM_LATENCY >= 1, ADDR_WIDTH >= 2");
    end

    logic [1:0]             state_r;
    logic [1:0]             state_next_s;
    logic [KW-1:0]          pair_r;
    logic [2:0]             pass_r;
    logic [CW-1:0]          outstanding_r;
    logic [RAM_LATENCY-1:0] valid_sh_r;
    logic [RAM_LATENCY-1:0] last_sh_r;
    logic                   rden_r;
    logic                   rden_last_r;
    logic [ADDR_WIDTH-1:0]  address_a_r;
    logic [ADDR_WIDTH-1:0]  address_b_r;
    logic                   done_r;

    logic                   issue_s;
    logic                   issue_last_s;
    logic                   drained_s;
    logic                   pop_s;
    logic                   push_s;
    logic [CW:0]            credit_used_s;
    logic [FW-1:0]          head_s;
    logic                   head_valid_s;
    logic [CW-1:0]          fifo_count_s;

    assign pop_s  = head_valid_s & out_ready;
    assign push_s = valid_sh_r[RAM_LATENCY-1];

    // A pair leaving the FIFO this cycle frees its slot for the next issue.
    assign credit_used_s = {1'b0, outstanding_r} + {1'b0, fifo_count_s} - {{CW{1'b0}}, pop_s};
    assign issue_s       = (state_r == ST_READ) && enable && (credit_used_s < (CW + 1)'(FIFO_DEPTH));
    assign issue_last_s  = (pair_r == LAST_PAIR) && (pass_r == LAST_PASS);
    assign drained_s     = (outstanding_r == {CW{1'b0}}) &&
                           ((fifo_count_s == {CW{1'b0}}) || ((fifo_count_s == CW'(1)) && pop_s));

    // Next-state logic of the read sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  if (enable) state_next_s = ST_READ;  else state_next_s = ST_IDLE;
            ST_READ:  if (issue_s && issue_last_s) state_next_s = ST_DRAIN; else state_next_s = ST_READ;
            ST_DRAIN: if (drained_s) state_next_s = ST_DONE; else state_next_s = ST_DRAIN;
            ST_DONE:  state_next_s = ST_DONE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Sequencer state, pair/pass counters, registered RAM port and latency tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pair_r        <= {KW{1'b0}};
            pass_r        <= 3'd0;
            outstanding_r <= {CW{1'b0}};
            valid_sh_r    <= {RAM_LATENCY{1'b0}};
            last_sh_r     <= {RAM_LATENCY{1'b0}};
            rden_r        <= 1'b0;
            rden_last_r   <= 1'b0;
            address_a_r   <= {ADDR_WIDTH{1'b0}};
            address_b_r   <= {ADDR_WIDTH{1'b0}};
            done_r        <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            done_r      <= (state_next_s == ST_DONE);
            rden_r      <= issue_s;
            rden_last_r <= issue_s && issue_last_s;
            valid_sh_r  <= (valid_sh_r << 1) | RAM_LATENCY'(rden_r);
            last_sh_r   <= (last_sh_r << 1) | RAM_LATENCY'(rden_last_r);
            if (issue_s) begin
                address_a_r <= {pair_r, 1'b0};
                address_b_r <= {pair_r, 1'b1};
                if (pair_r == LAST_PAIR) begin
                    pair_r <= {KW{1'b0}};
                    pass_r <= pass_r + 3'd1;
                end else begin
                    pair_r <= pair_r + KW'(1);
                    pass_r <= pass_r;
                end
            end else begin
                address_a_r <= {ADDR_WIDTH{1'b0}};
                address_b_r <= {ADDR_WIDTH{1'b0}};
            end
            case ({issue_s, push_s})
                2'b10:   outstanding_r <= outstanding_r + CW'(1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

`ifdef FCREAD_MULTIPASS_EN
    logic [2:0] pass_idx_r;

    // Pass of the most recently issued pair, aligned with rden.
    always_ff @(posedge clock) begin
        if (reset) begin
            pass_idx_r <= 3'd0;
        end else if (issue_s) begin
            pass_idx_r <= pass_r;
        end else begin
            pass_idx_r <= pass_idx_r;
        end
    end

    assign pass_idx = pass_idx_r;
`else
    assign pass_idx = 3'd0;
`endif

    convfc_read_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push_s),
        .push_data  ({last_sh_r[RAM_LATENCY-1], q_a, q_b}),
        .pop        (pop_s),
        .head_data  (head_s),
        .head_valid (head_valid_s),
        .count      (fifo_count_s)
    );

    assign rden_a     = rden_r;
    assign rden_b     = rden_r;
    assign wren_a     = 1'b0;
    assign wren_b     = 1'b0;
    assign address_a  = address_a_r;
    assign address_b  = address_b_r;
    assign out_valid  = head_valid_s;
    assign out_last   = head_s[FW-1];
    assign out_data_a = head_s[2*DATA_WIDTH-1:DATA_WIDTH];
    assign out_data_b = head_s[DATA_WIDTH-1:0];
    assign done       = done_r;

endmodule

// File: tb/tb_layer_inter_convfc_reader.sv
// Scoreboard bench for layer_inter_convfc_reader: a RAM model answers reads, the
// expected address and pair streams are queued per run and checked by a monitor.
module tb_layer_inter_convfc_reader;

    localparam int AW     = 5;
    localparam int DW     = 16;
    localparam int NW     = 8;
    localparam int LAT    = 2;
    localparam int NP_CFG = 3;
`ifdef FCREAD_MULTIPASS_EN
    localparam int PASSES = NP_CFG;
`else
    localparam int PASSES = 1;
`endif
    localparam int PAIRS  = NW / 2;
    localparam int DEPTH  = LAT + 2;

    logic          clock = 1'b0;
    logic          reset, enable, out_ready;
    logic          rden_a, rden_b, wren_a, wren_b;
    logic [AW-1:0] address_a, address_b;
    logic [DW-1:0] q_a, q_b;
    logic          out_valid, out_last, done;
    logic [DW-1:0] out_data_a, out_data_b;
    logic [2:0]    pass_idx;

    always #5 clock = ~clock;

    layer_inter_convfc_reader #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_WORDS (NW),
        .RAM_LATENCY (LAT), .NUM_PASSES (NP_CFG)
    ) dut (
        .clock (clock), .reset (reset), .enable (enable),
        .rden_a (rden_a), .rden_b (rden_b), .wren_a (wren_a), .wren_b (wren_b),
        .address_a (address_a), .address_b (address_b), .q_a (q_a), .q_b (q_b),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_data_a (out_data_a), .out_data_b (out_data_b),
        .out_last (out_last), .pass_idx (pass_idx), .done (done)
    );

    // Dual-port RAM model with LAT cycles from rden to data
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] pa [LAT];
    logic [DW-1:0] pb [LAT];
    always @(posedge clock) begin
        pa[0] <= rden_a ? mem[address_a] : 16'hDEAD;
        pb[0] <= rden_b ? mem[address_b] : 16'hBEEF;
        for (int i = 1; i < LAT; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign q_a = pa[LAT-1];
    assign q_b = pb[LAT-1];

    typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic last; } pair_t;
    typedef struct { int k; int pass; } addr_t;

    pair_t exp_q[$];
    addr_t addr_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    int    issued = 0;
    int    accepted = 0;
    logic  done_exp = 1'b0;
    logic  prev_en = 1'b0;
    logic  stalled = 1'b0;
    pair_t held;
    pair_t ex;
    addr_t ea;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected stream for one full run: every pass reads pairs 0..PAIRS-1 in order
    task automatic start_run();
        exp_q.delete();
        addr_q.delete();
        for (int p = 0; p < PASSES; p++) begin
            for (int k = 0; k < PAIRS; k++) begin
                addr_q.push_back('{k: k, pass: p});
                exp_q.push_back('{a: mem[2*k], b: mem[2*k+1], last: (p == PASSES-1 && k == PAIRS-1)});
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        addr_q.delete();
        issued = 0;
        accepted = 0;
        @(posedge clock); #1;
        chk("reset_outputs", {rden_a, rden_b, wren_a, wren_b, address_a, address_b, out_valid,
                              out_data_a, out_data_b, out_last, pass_idx, done}, 64'd0);
        reset = 1'b0;
    endtask

    // mode 0: ready high; 1: ready toggles each cycle; 2: random ready and enable
    task automatic run_until_done(input int mode, input string name);
        int n;
        n = 0;
        enable = 1'b1;
        while (!done && n < 3000) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: begin
                    out_ready = 1'($urandom_range(0, 1));
                    enable = ($urandom_range(0, 3) != 0);
                end
            endcase
            @(posedge clock); #1;
            n++;
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_all_pairs"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_all_reads"}, 64'(addr_q.size()), 64'd0);
    endtask

    // Monitor: address stream, credit bound, handshake stability, data and done
    always @(negedge clock) begin
        if (reset) begin
            done_exp = 1'b0;
            stalled = 1'b0;
            prev_en = 1'b0;
        end else begin
            chk("done", 64'(done), 64'(done_exp));
            chk("wren", {62'd0, wren_a, wren_b}, 64'd0);
            if (rden_a) begin
                chk("rden_b", 64'(rden_b), 64'd1);
                chk("rden_after_enable", 64'(prev_en), 64'd1);
                if (addr_q.size() == 0) begin
                    chk("rden_unexpected", 64'(rden_a), 64'd0);
                end else begin
                    ea = addr_q.pop_front();
                    chk("address_a", 64'(address_a), 64'(2*ea.k));
                    chk("address_b", 64'(address_b), 64'(2*ea.k+1));
                    chk("pass_idx", 64'(pass_idx), 64'(ea.pass));
                end
                issued++;
                chk("credit_bound", 64'((issued - accepted) <= DEPTH), 64'd1);
            end else begin
                chk("rden_b_idle", 64'(rden_b), 64'd0);
            end
            if (stalled) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", {31'd0, out_last, out_data_a, out_data_b},
                                  {31'd0, held.last, held.a, held.b});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("output_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    ex = exp_q.pop_front();
                    chk("out_pair", {31'd0, out_last, out_data_a, out_data_b},
                                    {31'd0, ex.last, ex.a, ex.b});
                    accepted++;
                    if (ex.last) done_exp = 1'b1;
                end
            end
            stalled = out_valid && !out_ready;
            held = '{a: out_data_a, b: out_data_b, last: out_last};
            prev_en = enable;
        end
    end

    initial begin
        int t, t_first, t_ov, t_done, seen;
        reset = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // Full-rate run: latency to first output and to done
        start_run();
        enable = 1'b1;
        out_ready = 1'b1;
        t = 0; t_first = -1; t_ov = -1; t_done = -1;
        while (t_done < 0 && t < 500) begin
            @(posedge clock); #1;
            t++;
            if (rden_a && t_first < 0) t_first = t;
            if (out_valid && t_ov < 0) t_ov = t;
            if (done) t_done = t;
        end
        chk("t1_first_out_latency", 64'(t_ov - t_first), 64'(LAT + 1));
        chk("t1_done_latency", 64'(t_done - t_first), 64'(PASSES*PAIRS + LAT + 1));
        chk("t1_all_pairs", 64'(exp_q.size()), 64'd0);

        // done holds and no reads happen while inputs wiggle
        for (int i = 0; i < 20; i++) begin
            enable = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            chk("t6_done_hold", 64'(done), 64'd1);
        end

        // Backpressure toggling every cycle
        do_reset();
        start_run();
        out_ready = 1'b1;
        run_until_done(1, "t2_toggle");

        // enable dropped after two issues for five cycles
        do_reset();
        start_run();
        enable = 1'b1;
        out_ready = 1'b1;
        seen = 0; t = 0;
        while (seen < 2 && t < 50) begin
            @(posedge clock); #1;
            t++;
            if (rden_a) seen++;
        end
        enable = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
        end
        chk("t3_issued_while_low", 64'(issued), 64'd2);
        chk("t3_inflight_delivered", 64'(accepted), 64'd2);
        run_until_done(0, "t3_resume");

        // Reset with three reads in flight, then a clean restart
        do_reset();
        start_run();
        enable = 1'b1;
        out_ready = 1'b0;
        seen = 0; t = 0;
        while (seen < 3 && t < 50) begin
            @(posedge clock); #1;
            t++;
            if (rden_a) seen++;
        end
        chk("t4_reads_in_flight", 64'(seen), 64'd3);
        do_reset();
        start_run();
        run_until_done(0, "t4_restart");

        // Randomized data, enable and backpressure
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
            do_reset();
            start_run();
            run_until_done(2, "t5_random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
